systolic_feeder: RTL
====================

// Module: systolic_feeder
// PURPOSE
//  Drives the left and top edges of the 2x2 systolic array from unified-buffer streams.
//  Per command it loads one 2x2 weight tile, pulses switch, then streams N input rows with a one-cycle skew on row 2.
//  It also issues the column-size config and flags completion.
// PARAMETERS
//  SYSTOLIC_ARRAY_WIDTH  2   array edge; only 2 is legal (elaboration $error otherwise)
//  ROW_CNT_W             16  width of row counter / cmd_num_rows
// PORTS
//  clk                       in   1   clock
//  rst                       in   1   synchronous, active-high reset
//  cmd_valid / cmd_ready     in/out 1 command handshake; cmd_ready=1 only in IDLE
//  cmd_num_rows              in   ROW_CNT_W  input rows to stream (0 legal)
//  cmd_col_size              in   16  active columns; clamped to 2
//  w_valid / w_ready         in/out 1 weight-row handshake
//  w_data                    in   32  [15:0]=col1, [31:16]=col2
//  in_valid / in_ready       in/out 1 input-row handshake
//  in_data                   in   32  [15:0]=array row1, [31:16]=array row2
//  sys_data_in_11/_21        out  16  left-edge data, row2 skewed +1 cycle
//  sys_start                 out  1   valid, aligned with sys_data_in_11
//  sys_weight_in_11/_12      out  16  top-edge weights
//  sys_accept_w_1/_2         out  1   weight shift enables per column
//  sys_switch_in             out  1   shadow->active weight copy pulse
//  ub_rd_col_size_out        out  16  clamped column size
//  ub_rd_col_size_valid_out  out  1   one-cycle pulse
//  done                      out  1   one-cycle completion pulse
//  stall_cnt                 out  16  see CONFIGURATION
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset, including mid-operation: FSM->IDLE; all sys_*, done and counters 0; skew register 0.
//  - FSM states: IDLE -> LOAD_W -> SWITCH -> STREAM -> DRAIN -> DONE -> IDLE.
//  - IDLE: on cmd_valid&cmd_ready at edge k:
//      latch num_rows and min(col_size,2); go LOAD_W;
//      ub_rd_col_size_valid_out=1 in cycle k+1 only.
//  - LOAD_W: w_ready=1; two beats; first beat = bottom-row weights, second = top-row.
//      Each handshake at edge e: sys_weight_in_1x=w_data and sys_accept_w_1/_2=1 in cycle e+1.
//      Otherwise accept_w=0 and weights hold. No w_valid: stall indefinitely.
//  - SWITCH: entered after 2nd beat; sys_switch_in=1 for exactly one cycle.
//      Next state: STREAM, or DONE if num_rows==0.
//  - STREAM: in_ready=1 (array never back-pressures).
//      Handshake at edge e: sys_data_in_11=in_data[15:0] and sys_start=1 in e+1;
//      sys_data_in_21=in_data[31:16] in e+2.
//      No handshake: bubble, data_in_11=0, sys_start=0; skew lane still shifts.
//      Decrement row counter per handshake; after last row go DRAIN.
//  - DRAIN: 1 cycle (WIDTH-1), flushes skew lane; in_ready=0. Then DONE.
//  - DONE: done=1 for one cycle; -> IDLE.
//  - w_ready=0 outside LOAD_W; in_ready=0 outside STREAM.
//  - Beats offered in the wrong state are ignored (not consumed).
//  - cmd_col_size>2 clamps to 2; 0 is passed through (array columns idle).
// CONFIGURATION
//  FEEDER_STALL_CNT_EN defined:
//    stall_cnt counts STREAM cycles with in_valid=0; saturates at 16'hFFFF.
//    Cleared on command accept; holds after done.
//  Undefined: stall_cnt tied to 0, no counter logic.
// TESTING
//  - Reset mid-STREAM (row 2 of 4): next cycle all outputs 0, cmd_ready=1;
//    fresh command completes normally.
//  - cmd(rows=3,col=2), w beats {2,1},{4,3}, rows {5,6},{7,8},{9,10} back-to-back:
//    accept_w high 2 cycles with weights (1,2) then (3,4); switch 1 cycle later;
//    data_11 = 5,7,9 with sys_start; data_21 = 6,8,10 one cycle later;
//    done 2 cycles after last data_11.
//  - in_valid gaps during STREAM: sys_start low exactly in gap cycles;
//    row2 skew preserved; stall_cnt = gap count with FEEDER_STALL_CNT_EN.
//  - cmd_num_rows=0: weights load, switch pulses, done next cycle, no sys_start.
//  - cmd_col_size=5: ub_rd_col_size_out=2 with a 1-cycle valid pulse.
//  - w_valid withheld 10 cycles in LOAD_W: no accept_w, no switch; resumes on w_valid.

Source files
------------

// File: rtl/systolic_feeder_if.sv
// Bus bundle between the unified-buffer side and the 2x2 systolic array feeder.
// The slave modport is the feeder's view; master is the view of whatever drives commands and streams.
interface systolic_feeder_if #(
  parameter int ROW_CNT_W = 16
);
  logic                 cmd_valid;
  logic                 cmd_ready;
  logic [ROW_CNT_W-1:0] cmd_num_rows;
  logic [15:0]          cmd_col_size;
  logic                 w_valid;
  logic                 w_ready;
  logic [31:0]          w_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [31:0]          in_data;
  logic [15:0]          sys_data_in_11;
  logic [15:0]          sys_data_in_21;
  logic                 sys_start;
  logic [15:0]          sys_weight_in_11;
  logic [15:0]          sys_weight_in_12;
  logic                 sys_accept_w_1;
  logic                 sys_accept_w_2;
  logic                 sys_switch_in;
  logic [15:0]          ub_rd_col_size_out;
  logic                 ub_rd_col_size_valid_out;
  logic                 done;
  logic [15:0]          stall_cnt;

  modport slave (
    input  cmd_valid, cmd_num_rows, cmd_col_size, w_valid, w_data, in_valid, in_data,
    output cmd_ready, w_ready, in_ready,
    output sys_data_in_11, sys_data_in_21, sys_start, sys_weight_in_11, sys_weight_in_12,
    output sys_accept_w_1, sys_accept_w_2, sys_switch_in,
    output ub_rd_col_size_out, ub_rd_col_size_valid_out, done, stall_cnt
  );

  modport master (
    output cmd_valid, cmd_num_rows, cmd_col_size, w_valid, w_data, in_valid, in_data,
    input  cmd_ready, w_ready, in_ready,
    input  sys_data_in_11, sys_data_in_21, sys_start, sys_weight_in_11, sys_weight_in_12,
    input  sys_accept_w_1, sys_accept_w_2, sys_switch_in,
    input  ub_rd_col_size_out, ub_rd_col_size_valid_out, done, stall_cnt
  );
endinterface

// File: rtl/systolic_feeder.sv
// Feeds weights, a switch pulse and skewed input rows into the edges of a 2x2 systolic array.
// Optional macro FEEDER_STALL_CNT_EN enables the saturating STREAM stall counter on stall_cnt.
module systolic_feeder #(
  parameter int SYSTOLIC_ARRAY_WIDTH = 2,
  parameter int ROW_CNT_W            = 16
) (
  input logic               clk,
  input logic               rst,
  systolic_feeder_if.slave  bus
);

  if (SYSTOLIC_ARRAY_WIDTH != 2) begin : g_bad_width
    $error("systolic_feeder: SYSTOLIC_ARRAY_WIDTH must be 2");
  end

  typedef enum logic [2:0] {IDLE, LOAD_W, SWITCH, STREAM, DRAIN, DONE} state_t;

  state_t               state_q, state_d;
  logic                 beat_q, beat_d;
  logic [ROW_CNT_W-1:0] rowCnt_q, rowCnt_d;
  logic                 cmdFire, wFire, inFire;

  logic [15:0] data11_q, data21_q, skew_q;
  logic        start_q;
  logic [15:0] weight11_q, weight12_q;
  logic        acceptW_q, switch_q, done_q;
  logic [15:0] colSize_q;
  logic        colSizeValid_q;

  assign bus.cmd_ready = (state_q == IDLE);
  assign bus.w_ready   = (state_q == LOAD_W);
  assign bus.in_ready  = (state_q == STREAM);

  assign cmdFire = bus.cmd_valid & bus.cmd_ready;
  assign wFire   = bus.w_valid   & bus.w_ready;
  assign inFire  = bus.in_valid  & bus.in_ready;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      beat_q   <= 1'b0;
      rowCnt_q <= '0;
    end else begin
      state_q  <= state_d;
      beat_q   <= beat_d;
      rowCnt_q <= rowCnt_d;
    end
  end

  // beat_q marks that the bottom-row weights have been taken and the top row is next.
  always_comb begin
    state_d  = state_q;
    beat_d   = beat_q;
    rowCnt_d = rowCnt_q;
    case (state_q)
      IDLE: begin
        if (cmdFire) begin
          state_d  = LOAD_W;
          beat_d   = 1'b0;
          rowCnt_d = bus.cmd_num_rows;
        end
      end
      LOAD_W: begin
        if (wFire) begin
          beat_d = 1'b1;
          if (beat_q) begin
            state_d = SWITCH;
            beat_d  = 1'b0;
          end
        end
      end
      SWITCH:  state_d = (rowCnt_q == '0) ? DONE : STREAM;
      STREAM: begin
        if (inFire) begin
          rowCnt_d = rowCnt_q - ROW_CNT_W'(1);
          if (rowCnt_q == ROW_CNT_W'(1)) state_d = DRAIN;
        end
      end
      DRAIN:   state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Row 2 goes through skew_q so it reaches the array one cycle after row 1; bubbles shift zeros.
  always_ff @(posedge clk) begin
    if (rst) begin
      data11_q       <= '0;
      data21_q       <= '0;
      skew_q         <= '0;
      start_q        <= 1'b0;
      weight11_q     <= '0;
      weight12_q     <= '0;
      acceptW_q      <= 1'b0;
      switch_q       <= 1'b0;
      done_q         <= 1'b0;
      colSize_q      <= '0;
      colSizeValid_q <= 1'b0;
    end else begin
      data11_q       <= inFire ? bus.in_data[15:0]  : 16'd0;
      skew_q         <= inFire ? bus.in_data[31:16] : 16'd0;
      data21_q       <= skew_q;
      start_q        <= inFire;
      acceptW_q      <= wFire;
      switch_q       <= (state_q == SWITCH);
      done_q         <= (state_q == DONE);
      colSizeValid_q <= cmdFire;
      if (wFire) begin
        weight11_q <= bus.w_data[15:0];
        weight12_q <= bus.w_data[31:16];
      end
      if (cmdFire) colSize_q <= (bus.cmd_col_size > 16'd2) ? 16'd2 : bus.cmd_col_size;
    end
  end

  assign bus.sys_data_in_11           = data11_q;
  assign bus.sys_data_in_21           = data21_q;
  assign bus.sys_start                = start_q;
  assign bus.sys_weight_in_11         = weight11_q;
  assign bus.sys_weight_in_12         = weight12_q;
  assign bus.sys_accept_w_1           = acceptW_q;
  assign bus.sys_accept_w_2           = acceptW_q;
  assign bus.sys_switch_in            = switch_q;
  assign bus.done                     = done_q;
  assign bus.ub_rd_col_size_out       = colSize_q;
  assign bus.ub_rd_col_size_valid_out = colSizeValid_q;

`ifdef FEEDER_STALL_CNT_EN
  logic [15:0] stallCnt_q;

  // Restarts per command and stays readable after done until the next accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      stallCnt_q <= '0;
    end else if (cmdFire) begin
      stallCnt_q <= '0;
    end else if ((state_q == STREAM) && !bus.in_valid && (stallCnt_q != 16'hFFFF)) begin
      stallCnt_q <= stallCnt_q + 16'd1;
    end
  end

  assign bus.stall_cnt = stallCnt_q;
`else
  assign bus.stall_cnt = '0;
`endif

endmodule
